// File: rtl/uart_rx_oversampled_pkg.sv
// uart_rx_oversampled_pkg: shared FSM states, oversampling default and baud divider helper
package uart_rx_oversampled_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;

    // Clocks per sample tick; shared with the transmitter's baud logic.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// uart_rx_oversampled_if: received-byte handshake plus status flags toward the host/FIFO
interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_oversampled_baud_tick.sv
// uart_rx_oversampled_baud_tick: sample-tick divider with synchronous phase-align clear
module uart_rx_oversampled_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(DIV) > 0 ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = cnt == W'(DIV - 1);

    // Count 0..DIV-1; clr restarts the phase at a detected start edge
    always_ff @(posedge clk)
        if (!reset || clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;

endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampling UART receiver with 3-sample majority vote and held output byte
module uart_rx_oversampled
    import uart_rx_oversampled_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = 8
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  rx,
    uart_rx_oversampled_if.master bus
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);

    logic                 s1;
    logic                 rxs;
    state_t               state;
    state_t               next;
    logic [TW-1:0]        t;
    logic [BW-1:0]        nbits;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 fe_q;
    logic                 ov_q;
    logic                 tick;
    logic                 clr;
    logic                 decide;
    logic                 wrap;
    logic                 bitv;
    logic                 deliver;
    logic                 fail;

    uart_rx_oversampled_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .tick (tick)
    );

    assign clr    = state == IDLE && !rxs;
    assign decide = tick && t == TW'(M + 1);
    assign wrap   = tick && t == TW'(OVERSAMPLE - 1);
    // Two earlier samples plus the live one at the decide tick
    assign bitv   = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk)
        if (!reset)
            {s1, rxs} <= 2'b11;
        else
            {s1, rxs} <= {rx, s1};

    // FSM state register
    always_ff @(posedge clk)
        if (!reset)
            state <= IDLE;
        else
            state <= next;

    // Next state plus single-cycle delivery / framing-failure strobes
    always_comb begin
        next    = state;
        deliver = 1'b0;
        fail    = 1'b0;
        case (state)
            IDLE:    if (!rxs) next = START;
            START:   if (decide && bitv) next = IDLE;
                     else if (wrap) next = DATA;
            DATA:    if (wrap && nbits == BW'(DATA_BITS)) next = STOP;
            STOP:    if (decide) begin
                         next    = bitv ? IDLE : BREAK;
                         deliver = bitv;
                         fail    = !bitv;
                     end
            BREAK:   if (rxs) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Tick index, sample history, bit count and LSB-first shift register
    always_ff @(posedge clk)
        if (!reset) begin
            t     <= '0;
            nbits <= '0;
            smp   <= '0;
            shreg <= '0;
        end else begin
            if (state == IDLE) begin
                t     <= '0;
                nbits <= '0;
            end else if (tick)
                t <= wrap ? '0 : t + 1'b1;
            if (tick && (t == TW'(M - 1) || t == TW'(M)))
                smp <= {smp[0], rxs};
            if (state == DATA && decide) begin
                shreg <= {bitv, shreg[DATA_BITS-1:1]};
                nbits <= nbits + 1'b1;
            end
        end

    // Holding register: a full register only takes a new byte when it drains the same cycle
    always_ff @(posedge clk)
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            fe_q <= fail;
            ov_q <= deliver && valid_q && !bus.rx_ready;
            if (deliver && (!valid_q || bus.rx_ready)) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && bus.rx_ready)
                valid_q <= 1'b0;
        end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = fe_q;
    assign bus.overrun   = ov_q;
    assign bus.busy      = state != IDLE;

endmodule
